// File: rtl/i_cache_2way_burst.sv
// ---------------------------------------------------------------------------
// i_cache_2way_burst
// Read-only, 2-way set-associative instruction cache. It sits between the
// core fetch port and the SRAM-like bridge port. A hit answers in the request
// cycle. A miss refills the whole line one word at a time, with one bridge
// transaction outstanding. The core keeps its request held, and the request
// then completes as a hit in the first IDLE cycle after the refill.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    blocks the start of a new refill (hits unaffected)
//   cpu_inst_req/addr        fetch request and word-aligned address
//   cpu_inst_wr/size/wdata   ignored (read-only cache, word fetches)
//   cpu_inst_rdata           hit word
//   cpu_inst_addr_ok/data_ok both high on a hit
//   cache_inst_req/addr      refill word read toward the bridge
//   cache_inst_wr/size/wdata constant read-word encoding
//   cache_inst_rdata         refill data
//   cache_inst_addr_ok       bridge accepted the refill address
//   cache_inst_data_ok       bridge returned the refill data
// ---------------------------------------------------------------------------
module i_cache_2way_burst #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);

    localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINE_WORDS = 1 << (OFFSET_WIDTH - 2);
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int WW         = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;

    typedef enum logic {IDLE, REFILL} state_e;

    // Storage (data and tags are not reset; valid/LRU are)
    logic [31:0]            data_q  [2][SETS][LINE_WORDS];
    logic [TAG_WIDTH-1:0]   tag_q   [2][SETS];
    logic [SETS-1:0]        valid_q [2];
    logic [SETS-1:0]        lru_q;

    // Control state
    state_e                 state_q, state_d;
    logic [WW-1:0]          k_q, k_d;
    logic                   sent_q, sent_d;   // refill address accepted, awaiting data

    // Miss capture
    logic [TAG_WIDTH-1:0]   tag_save_q;
    logic [INDEX_WIDTH-1:0] index_save_q;
    logic                   victim_q, victim_d;

    // Request decode
    logic [TAG_WIDTH-1:0]   cpu_tag;
    logic [INDEX_WIDTH-1:0] cpu_set;
    logic [WW-1:0]          cpu_word;
    logic                   hit0, hit1, hit, hit_way;
    logic                   start_refill, fill_word, fill_done, last_word;

    logic unused_inputs;
    assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

    assign cpu_tag  = cpu_inst_addr[31 -: TAG_WIDTH];
    assign cpu_set  = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_word = (OFFSET_WIDTH > 2) ? WW'(cpu_inst_addr[31:2]) : '0;

    assign hit0    = valid_q[0][cpu_set] && (tag_q[0][cpu_set] == cpu_tag);
    assign hit1    = valid_q[1][cpu_set] && (tag_q[1][cpu_set] == cpu_tag);
    // Hits are only reported from IDLE, so a half-filled line can never answer.
    assign hit     = !rst && (state_q == IDLE) && cpu_inst_req && (hit0 || hit1);
    assign hit_way = hit1 && !hit0;

    assign cpu_inst_rdata   = data_q[hit_way][cpu_set][cpu_word];
    assign cpu_inst_addr_ok = hit;
    assign cpu_inst_data_ok = hit;

    // Invalid ways are filled before anything valid is evicted.
    assign victim_d = !valid_q[0][cpu_set] ? 1'b0 :
                      !valid_q[1][cpu_set] ? 1'b1 : lru_q[cpu_set];

    assign last_word = (k_q == WW'(LINE_WORDS - 1));

    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = 2'b10;
    assign cache_inst_wdata = 32'h0;
    assign cache_inst_addr  = {tag_save_q, index_save_q, {OFFSET_WIDTH{1'b0}}}
                              | (32'(k_q) << 2);

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        sent_d         = sent_q;
        cache_inst_req = 1'b0;
        start_refill   = 1'b0;
        fill_word      = 1'b0;
        fill_done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_inst_req && !hit && !flush) begin
                    state_d      = REFILL;
                    k_d          = '0;
                    sent_d       = 1'b0;
                    start_refill = 1'b1;
                end
            end
            REFILL: begin
                // flush is deliberately ignored here: the line always completes.
                cache_inst_req = !sent_q;
                if (!sent_q && cache_inst_addr_ok) begin
                    sent_d = 1'b1;
                end
                if (cache_inst_data_ok) begin
                    fill_word = 1'b1;
                    sent_d    = 1'b0;
                    k_d       = k_q + WW'(1);
                    if (last_word) begin
                        fill_done = 1'b1;
                        k_d       = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            sent_q     <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sent_q  <= sent_d;
            if (hit) begin
                lru_q[cpu_set] <= ~hit_way;
            end
            // The valid bit is set only when the final word lands.
            if (fill_done) begin
                valid_q[victim_q][index_save_q] <= 1'b1;
                lru_q[index_save_q]             <= ~victim_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_refill) begin
            tag_save_q   <= cpu_tag;
            index_save_q <= cpu_set;
            victim_q     <= victim_d;
        end
        if (fill_word) begin
            data_q[victim_q][index_save_q][k_q] <= cache_inst_rdata;
        end
        if (fill_done) begin
            tag_q[victim_q][index_save_q] <= tag_save_q;
        end
    end

endmodule

// File: tb/tb_i_cache_2way_burst.sv
// ---------------------------------------------------------------------------
// tb_i_cache_2way_burst
// Directed bench for i_cache_2way_burst with default parameters (4-word lines,
// 64 sets). A task plays the bridge with configurable address and data delays.
// Bridge memory content is a fixed function of the address.
// ---------------------------------------------------------------------------
module tb_i_cache_2way_burst;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        cpu_inst_req, cpu_inst_wr;
    logic [1:0]  cpu_inst_size;
    logic [31:0] cpu_inst_addr, cpu_inst_wdata, cpu_inst_rdata;
    logic        cpu_inst_addr_ok, cpu_inst_data_ok;
    logic        cache_inst_req, cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr, cache_inst_wdata, cache_inst_rdata;
    logic        cache_inst_addr_ok, cache_inst_data_ok;

    int total = 0;
    int bad   = 0;
    int rcyc  = 0;
    int flush_at = -1;

    always #5 clk = ~clk;

    i_cache_2way_burst dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .cpu_inst_req       (cpu_inst_req),
        .cpu_inst_wr        (cpu_inst_wr),
        .cpu_inst_size      (cpu_inst_size),
        .cpu_inst_addr      (cpu_inst_addr),
        .cpu_inst_wdata     (cpu_inst_wdata),
        .cpu_inst_rdata     (cpu_inst_rdata),
        .cpu_inst_addr_ok   (cpu_inst_addr_ok),
        .cpu_inst_data_ok   (cpu_inst_data_ok),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_rdata   (cache_inst_rdata),
        .cache_inst_addr_ok (cache_inst_addr_ok),
        .cache_inst_data_ok (cache_inst_data_ok)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle forward; inputs change and outputs are sampled just after negedge.
    task automatic adv();
        @(negedge clk);
        #1;
        rcyc++;
        flush = (rcyc == flush_at);
    endtask

    // Bridge model: serves one full line refill in ascending word order.
    task automatic serve(input logic [31:0] base, input int ad, input int dd);
        int n;
        rcyc = 0;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (cache_inst_req !== 1'b1 && n < 40) begin
                adv();
                n++;
            end
            if (cache_inst_req !== 1'b1) begin
                chk("req_timeout", 32'd0, 32'd1);
                flush = 1'b0;
                return;
            end
            chk("refill_addr", cache_inst_addr, base + 32'(4 * w));
            for (int s = 0; s < ad; s++) begin
                adv();
                chk("req_hold", 32'(cache_inst_req), 32'd1);
            end
            cache_inst_addr_ok = 1'b1;
            adv();
            cache_inst_addr_ok = 1'b0;
            chk("req_drop", 32'(cache_inst_req), 32'd0);
            for (int s = 0; s < dd; s++) begin
                adv();
                chk("req_wait", 32'(cache_inst_req), 32'd0);
            end
            cache_inst_data_ok = 1'b1;
            cache_inst_rdata   = mem(base + 32'(4 * w));
            adv();
            cache_inst_data_ok = 1'b0;
            cache_inst_rdata   = 32'h0;
        end
        flush = 1'b0;
    endtask

    task automatic miss_fill(input logic [31:0] a, input int ad, input int dd);
        @(negedge clk);
        #1;
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = a;
        #1;
        chk("miss_no_ok", 32'(cpu_inst_data_ok), 32'd0);
        serve(a & ~32'hF, ad, dd);
        chk("replay_ok", 32'(cpu_inst_data_ok), 32'd1);
        chk("replay_data", cpu_inst_rdata, mem(a));
    endtask

    task automatic fetch_hit(input logic [31:0] a);
        @(negedge clk);
        #1;
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = a;
        #1;
        chk("hit_ok", 32'(cpu_inst_data_ok), 32'd1);
        chk("hit_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);
        chk("hit_data", cpu_inst_rdata, mem(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        cpu_inst_req = 1'b0; cpu_inst_wr = 1'b0; cpu_inst_size = 2'b10;
        cpu_inst_addr = 32'h0; cpu_inst_wdata = 32'h0;
        cache_inst_rdata = 32'h0; cache_inst_addr_ok = 1'b0; cache_inst_data_ok = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cache_req", 32'(cache_inst_req), 32'd0);
        chk("rst_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(cpu_inst_data_ok), 32'd0);
        chk("const_wr", 32'(cache_inst_wr), 32'd0);
        chk("const_size", 32'(cache_inst_size), 32'd2);
        chk("const_wdata", cache_inst_wdata, 32'd0);
        rst = 1'b0;

        // Cold miss: 8 refill cycles, hit on the 9th cycle after the request
        @(negedge clk);
        #1;
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = 32'hBFC0_0004;
        #1;
        chk("cold_no_ok", 32'(cpu_inst_data_ok), 32'd0);
        chk("cold_idle_req", 32'(cache_inst_req), 32'd0);
        serve(32'hBFC0_0000, 0, 0);
        chk("miss_latency", 32'(rcyc), 32'd9);
        chk("cold_replay_ok", 32'(cpu_inst_data_ok), 32'd1);
        chk("cold_replay_data", cpu_inst_rdata, mem(32'hBFC0_0004));
        fetch_hit(32'hBFC0_000C);
        fetch_hit(32'hBFC0_0000);

        // Set conflict: A, B, A, C -> C evicts B
        miss_fill(32'h0000_0100, 0, 0);
        miss_fill(32'h0000_1100, 0, 0);
        fetch_hit(32'h0000_0100);
        miss_fill(32'h0000_2100, 0, 0);
        fetch_hit(32'h0000_0100);
        miss_fill(32'h0000_1100, 0, 0);
        fetch_hit(32'h0000_0100);

        // Bridge stalls
        miss_fill(32'h0000_3044, 3, 5);
        fetch_hit(32'h0000_3040);
        fetch_hit(32'h0000_3048);
        fetch_hit(32'h0000_304C);

        // flush in the 2nd REFILL cycle does not abort the refill
        flush_at = 2;
        miss_fill(32'h0000_4080, 0, 0);
        flush_at = -1;
        flush = 1'b0;
        fetch_hit(32'h0000_4084);
        fetch_hit(32'h0000_408C);

        // Miss with flush in IDLE: no refill starts
        @(negedge clk);
        #1;
        flush = 1'b1;
        cpu_inst_addr = 32'h0000_5000;
        #1;
        chk("flush_miss_ok", 32'(cpu_inst_data_ok), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("flush_no_req", 32'(cache_inst_req), 32'd0);
        end
        flush = 1'b0;
        cpu_inst_req = 1'b0;

        // rst mid-refill, then a stray data_ok
        @(negedge clk);
        #1;
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = 32'h0000_6000;
        @(negedge clk);
        #1;
        chk("rst_test_req", 32'(cache_inst_req), 32'd1);
        chk("rst_test_addr", cache_inst_addr, 32'h0000_6000);
        cache_inst_addr_ok = 1'b1;
        @(negedge clk);
        #1;
        cache_inst_addr_ok = 1'b0;
        rst = 1'b1;
        cpu_inst_req = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("after_rst_req", 32'(cache_inst_req), 32'd0);
        cache_inst_data_ok = 1'b1;
        cache_inst_rdata   = 32'h1234_5678;
        @(negedge clk);
        #1;
        cache_inst_data_ok = 1'b0;
        cache_inst_rdata   = 32'h0;
        chk("stray_ignored", 32'(cache_inst_req), 32'd0);
        miss_fill(32'h0000_6000, 0, 1);
        miss_fill(32'hBFC0_0004, 1, 0);

        // Hit with cpu_inst_wr=1: read-only behaviour
        @(negedge clk);
        #1;
        cpu_inst_wr    = 1'b1;
        cpu_inst_wdata = 32'hDEAD_BEEF;
        cpu_inst_addr  = 32'h0000_6008;
        #1;
        chk("wr_hit_ok", 32'(cpu_inst_data_ok), 32'd1);
        chk("wr_hit_data", cpu_inst_rdata, mem(32'h0000_6008));
        chk("wr_cache_wr", 32'(cache_inst_wr), 32'd0);
        chk("wr_cache_req", 32'(cache_inst_req), 32'd0);
        @(negedge clk);
        #1;
        cpu_inst_wr = 1'b0;
        fetch_hit(32'h0000_6008);
        fetch_hit(32'h0000_6000);

        @(negedge clk);
        cpu_inst_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
